// File: rtl/ring_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : ring_scan_display
//  Description : Scans a 4-digit multiplexed 7-segment display using the
//                one-hot phase of an upstream 4-bit ring counter as the digit
//                strobe. Display data is double-buffered: a load goes into a
//                shadow register and is committed only when the ring reaches
//                digit 0, so a revolution never shows a mix of old and new
//                digits. The ring is also monitored for illegal patterns
//                (sticky err), for a phase that stops moving (stall), and
//                completed 1000->0001 revolutions are counted.
//
//  Parameters  : REV_W      width of the revolution counter (wraps)
//                STALL_CYC  consecutive identical phase samples that raise
//                           stall (must be >= 2)
//
//  Ports       : clk      system clock, rising edge
//                reset    synchronous, active-low reset
//                phase    one-hot ring phase; bit i strobes digit i
//                load     capture din into the shadow buffer
//                din      four hex nibbles; digit i = din[4i+3:4i]
//                seg      segments {g,f,e,d,c,b,a}, active-high, registered
//                an       digit enables, active-high, registered
//                pend     shadow holds a value not yet committed
//                err      sticky illegal-phase flag
//                stall    phase held unchanged for STALL_CYC samples
//                rev_cnt  completed revolutions, modulo 2^REV_W
//
//  Options     : `define BLANK_LEAD_EN to blank leading zero digits
//                (digits 3..1); digit 0 is never blanked.
//
//  Revision    : 1.0  initial release
// ============================================================================
module ring_scan_display #(
    parameter int REV_W     = 8,
    parameter int STALL_CYC = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       phase,
    input  logic             load,
    input  logic [15:0]      din,
    output logic [6:0]       seg,
    output logic [3:0]       an,
    output logic             pend,
    output logic             err,
    output logic             stall,
    output logic [REV_W-1:0] rev_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The stall counter only has to reach STALL_CYC-1, where it saturates.
    localparam int               c_CNT_W    = $clog2(STALL_CYC);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STALL_CYC - 1);
    // Counter value (before this edge's increment) at which the current
    // sample becomes the STALL_CYC-th identical one.
    localparam logic [c_CNT_W-1:0] c_CNT_HIT = c_CNT_W'(STALL_CYC - 2);

    localparam logic [3:0]       c_PH_D0    = 4'b0001;
    localparam logic [3:0]       c_PH_D3    = 4'b1000;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [15:0]        r_disp;       // value currently being displayed
    logic [15:0]        r_shd;        // shadow (staged) value
    logic               r_pend;
    logic [3:0]         r_prev;       // phase sampled on the previous edge
    logic [c_CNT_W-1:0] r_stall_cnt;
    logic               r_stall;
    logic               r_err;
    logic [6:0]         r_seg;
    logic [3:0]         r_an;
    logic [REV_W-1:0]   r_rev;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic        w_legal;
    logic        w_commit;
    logic [15:0] w_src;
    logic [1:0]  w_sel;
    logic [3:0]  w_nib;
    logic        w_upper_zero;
    logic [6:0]  w_seg_dec;
    logic [6:0]  w_seg_nxt;
    logic        w_same;
    logic        w_rev_edge;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
    assign w_legal    = (phase != 4'd0) && ((phase & (phase - 4'd1)) == 4'd0);

    // Digit-0 phase is always legal, so no extra legality term is needed.
    assign w_commit   = r_pend && (phase == c_PH_D0);

    // In the commit cycle the display register is still stale; forward the
    // shadow so digit 0 of the new revolution already shows the new value.
    assign w_src      = w_commit ? r_shd : r_disp;

    assign w_same     = (phase == r_prev);
    assign w_rev_edge = (r_prev == c_PH_D3) && (phase == c_PH_D0);

    // Digit index from the one-hot phase (only meaningful when legal).
    always_comb begin
        w_sel = 2'd0;
        case (phase)
            4'b0010: w_sel = 2'd1;
            4'b0100: w_sel = 2'd2;
            4'b1000: w_sel = 2'd3;
            default: w_sel = 2'd0;
        endcase
    end

    assign w_nib = w_src[{w_sel, 2'b00} +: 4];

    // True when the selected nibble and every nibble above it are zero.
    always_comb begin
        w_upper_zero = 1'b0;
        case (w_sel)
            2'd1:    w_upper_zero = (w_src[15:4]  == 12'd0);
            2'd2:    w_upper_zero = (w_src[15:8]  == 8'd0);
            2'd3:    w_upper_zero = (w_src[15:12] == 4'd0);
            default: w_upper_zero = 1'b0;
        endcase
    end

    // Hex to 7-segment, bit order {g,f,e,d,c,b,a}.
    always_comb begin
        w_seg_dec = 7'h00;
        case (w_nib)
            4'h0: w_seg_dec = 7'h3F;
            4'h1: w_seg_dec = 7'h06;
            4'h2: w_seg_dec = 7'h5B;
            4'h3: w_seg_dec = 7'h4F;
            4'h4: w_seg_dec = 7'h66;
            4'h5: w_seg_dec = 7'h6D;
            4'h6: w_seg_dec = 7'h7D;
            4'h7: w_seg_dec = 7'h07;
            4'h8: w_seg_dec = 7'h7F;
            4'h9: w_seg_dec = 7'h6F;
            4'hA: w_seg_dec = 7'h77;
            4'hB: w_seg_dec = 7'h7C;
            4'hC: w_seg_dec = 7'h39;
            4'hD: w_seg_dec = 7'h5E;
            4'hE: w_seg_dec = 7'h79;
            4'hF: w_seg_dec = 7'h71;
            default: w_seg_dec = 7'h00;
        endcase
    end

`ifdef BLANK_LEAD_EN
    // Leading-zero blanking; w_upper_zero is never set for digit 0.
    assign w_seg_nxt = w_upper_zero ? 7'h00 : w_seg_dec;
`else
    assign w_seg_nxt = w_seg_dec;
    // Blanking logic is unused in this build; keep lint quiet about it.
    logic w_unused;
    assign w_unused  = w_upper_zero;
`endif

    // ------------------------------------------------------------------------
    // Double buffer: shadow load and commit
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_disp <= 16'd0;
            r_shd  <= 16'd0;
            r_pend <= 1'b0;
        end else begin
            if (w_commit) begin
                r_disp <= r_shd;
            end
            // A load in the commit cycle stages the next value while the old
            // shadow commits; pend stays set for the following revolution.
            if (load) begin
                r_shd  <= din;
                r_pend <= 1'b1;
            end else if (w_commit) begin
                r_pend <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Display drive and illegal-phase flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_seg <= 7'h00;
            r_an  <= 4'h0;
            r_err <= 1'b0;
        end else if (w_legal) begin
            r_seg <= w_seg_nxt;
            r_an  <= phase;
        end else begin
            r_seg <= 7'h00;
            r_an  <= 4'h0;
            r_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Revolution counter and phase history
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev <= 4'd0;
            r_rev  <= '0;
        end else begin
            r_prev <= phase;
            if (w_rev_edge) begin
                r_rev <= r_rev + REV_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stall detector
    // ------------------------------------------------------------------------
    // r_stall_cnt counts edges on which the phase matched the previous
    // sample, so STALL_CYC identical samples correspond to the counter
    // reaching STALL_CYC-1 on this edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_stall     <= 1'b0;
        end else if (w_same) begin
            if (r_stall_cnt != c_CNT_MAX) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_W'(1);
            end
            if (r_stall_cnt >= c_CNT_HIT) begin
                r_stall <= 1'b1;
            end
        end else begin
            r_stall_cnt <= '0;
            r_stall     <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign seg     = r_seg;
    assign an      = r_an;
    assign pend    = r_pend;
    assign err     = r_err;
    assign stall   = r_stall;
    assign rev_cnt = r_rev;

endmodule
`default_nettype wire

// File: tb/tb_ring_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ring_scan_display
//  Description : Self-checking bench for ring_scan_display. Every driven
//                cycle pushes the expected output vector from a behavioural
//                model; the DUT outputs are captured after the edge and each
//                test task drains and compares both queues, plus targeted
//                checks against fixed values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ring_scan_display;

    localparam int REV_W     = 8;
    localparam int STALL_CYC = 16;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic [3:0]       phase = 4'd0;
    logic             load  = 1'b0;
    logic [15:0]      din   = 16'd0;
    logic [6:0]       seg;
    logic [3:0]       an;
    logic             pend;
    logic             err;
    logic             stall;
    logic [REV_W-1:0] rev_cnt;

    ring_scan_display #(
        .REV_W     (REV_W),
        .STALL_CYC (STALL_CYC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .phase   (phase),
        .load    (load),
        .din     (din),
        .seg     (seg),
        .an      (an),
        .pend    (pend),
        .err     (err),
        .stall   (stall),
        .rev_cnt (rev_cnt)
    );

    always #5 clk = ~clk;

    // {seg, an, pend, err, stall, rev_cnt}
    typedef logic [7+4+3+REV_W-1:0] vec_t;
    vec_t exp_q[$];
    vec_t obs_q[$];
    vec_t sb_e;
    vec_t sb_o;

    int n_checks = 0;
    int n_err    = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                 7'h39, 7'h5E, 7'h79, 7'h71};

    // Behavioural model state
    logic [15:0]      m_disp, m_shd;
    logic             m_pend, m_err, m_stall;
    logic [3:0]       m_prev, m_an;
    logic [6:0]       m_seg;
    logic [REV_W-1:0] m_rev;
    int               m_run;     // length of the current run of equal samples

`ifdef BLANK_LEAD_EN
    localparam logic [6:0] c_ZERO_HI = 7'h00;
`else
    localparam logic [6:0] c_ZERO_HI = 7'h3F;
`endif

    // Drive one cycle, predict its outcome, clock, capture the DUT outputs.
    task automatic step(input logic rn, input logic [3:0] ph,
                        input logic ld, input logic [15:0] d);
        logic        legal;
        logic        commit;
        logic [15:0] src;
        int          idx;
        reset = rn;
        phase = ph;
        load  = ld;
        din   = d;
        if (!rn) begin
            m_disp = 16'd0; m_shd = 16'd0; m_pend = 1'b0; m_err = 1'b0;
            m_stall = 1'b0; m_prev = 4'd0; m_an = 4'd0; m_seg = 7'd0;
            m_rev = '0; m_run = 1;
        end else begin
            legal  = ($countones(ph) == 1);
            commit = m_pend && (ph == 4'b0001);
            src    = commit ? m_shd : m_disp;
            if (legal) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (ph[i]) idx = i;
                m_seg = seg_tab[src[idx*4 +: 4]];
`ifdef BLANK_LEAD_EN
                if (idx > 0 && (src >> (4 * idx)) == 16'd0) m_seg = 7'd0;
`endif
                m_an = ph;
            end else begin
                m_seg = 7'd0;
                m_an  = 4'd0;
                m_err = 1'b1;
            end
            if (commit) begin
                m_disp = m_shd;
                m_pend = 1'b0;
            end
            if (ld) begin
                m_shd  = d;
                m_pend = 1'b1;
            end
            if (m_prev == 4'b1000 && ph == 4'b0001) m_rev = m_rev + 1'b1;
            if (ph == m_prev) m_run = (m_run < 1000) ? m_run + 1 : m_run;
            else              m_run = 1;
            m_stall = (m_run >= STALL_CYC);
            m_prev  = ph;
        end
        exp_q.push_back({m_seg, m_an, m_pend, m_err, m_stall, m_rev});
        @(posedge clk);
        #1;
        obs_q.push_back({seg, an, pend, err, stall, rev_cnt});
    endtask

    task automatic test_reset();
        step(1'b0, 4'b0010, 1'b1, 16'h1234);
        step(1'b0, 4'b0010, 1'b1, 16'h1234);
        n_checks++;
        if ({seg, an, pend, err, stall, rev_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got seg=%h an=%b pend=%b err=%b stall=%b rev=%0d, want all 0",
                     seg, an, pend, err, stall, rev_cnt);
        end
        while (exp_q.size() > 0) begin
            sb_e = exp_q.pop_front(); sb_o = obs_q.pop_front(); n_checks++;
            if (sb_o !== sb_e) begin n_err++; $display("FAIL reset_sb: got %h want %h", sb_o, sb_e); end
        end
    endtask

    task automatic test_load_rotate();
        logic [3:0] ph_l  [6] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic       pnd_l [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [6:0] seg_l [6] = '{7'h00, 7'h00, 7'h66, 7'h4F, 7'h5B, 7'h06};
        step(1'b1, 4'b0010, 1'b1, 16'h1234);
        n_checks++;
        if (pend !== 1'b1) begin n_err++; $display("FAIL load_pend: got %b want 1", pend); end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, ph_l[i], 1'b0, 16'h0);
            n_checks++;
            if (pend !== pnd_l[i]) begin
                n_err++; $display("FAIL rotate_pend step %0d: got %b want %b", i, pend, pnd_l[i]);
            end
            if (i >= 2) begin
                n_checks++;
                if ({an, seg} !== {ph_l[i], seg_l[i]}) begin
                    n_err++; $display("FAIL rotate_digit step %0d: got an=%b seg=%h want an=%b seg=%h",
                                      i, an, seg, ph_l[i], seg_l[i]);
                end
            end
        end
        while (exp_q.size() > 0) begin
            sb_e = exp_q.pop_front(); sb_o = obs_q.pop_front(); n_checks++;
            if (sb_o !== sb_e) begin n_err++; $display("FAIL rotate_sb: got %h want %h", sb_o, sb_e); end
        end
    endtask

    task automatic test_load_in_commit();
        logic [6:0] seg_l [3] = '{7'h77, c_ZERO_HI, c_ZERO_HI};
        step(1'b1, 4'b0010, 1'b1, 16'h00AB);
        step(1'b1, 4'b0100, 1'b0, 16'h0);
        step(1'b1, 4'b1000, 1'b0, 16'h0);
        step(1'b1, 4'b0001, 1'b1, 16'hFFFF);
        n_checks++;
        if ({an, seg, pend} !== {4'b0001, 7'h7C, 1'b1}) begin
            n_err++; $display("FAIL commit_load_d0: got an=%b seg=%h pend=%b want an=0001 seg=7c pend=1",
                              an, seg, pend);
        end
        step(1'b1, 4'b0010, 1'b0, 16'h0);
        step(1'b1, 4'b0100, 1'b0, 16'h0);
        step(1'b1, 4'b1000, 1'b0, 16'h0);
        // Model-based scoreboard covers digits 1..3 of 00AB; check 3 here too.
        n_checks++;
        if (seg !== seg_l[2]) begin n_err++; $display("FAIL commit_old_d3: got %h want %h", seg, seg_l[2]); end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'b0001 << i, 1'b0, 16'h0);
            n_checks++;
            if (seg !== 7'h71) begin n_err++; $display("FAIL commit_new_digit%0d: got %h want 71", i, seg); end
        end
        n_checks++;
        if (pend !== 1'b0) begin n_err++; $display("FAIL commit_new_pend: got %b want 0", pend); end
        while (exp_q.size() > 0) begin
            sb_e = exp_q.pop_front(); sb_o = obs_q.pop_front(); n_checks++;
            if (sb_o !== sb_e) begin n_err++; $display("FAIL commit_sb: got %h want %h", sb_o, sb_e); end
        end
    endtask

    task automatic test_illegal();
        logic [REV_W-1:0] rv;
        step(1'b1, 4'b0001, 1'b0, 16'h0);
        step(1'b1, 4'b0010, 1'b0, 16'h0);
        step(1'b1, 4'b0100, 1'b0, 16'h0);
        rv = m_rev;
        step(1'b1, 4'b0110, 1'b0, 16'h0);
        n_checks++;
        if ({an, seg, err} !== {4'b0000, 7'h00, 1'b1}) begin
            n_err++; $display("FAIL illegal_out: got an=%b seg=%h err=%b want an=0000 seg=00 err=1", an, seg, err);
        end
        step(1'b1, 4'b0001, 1'b0, 16'h0);
        n_checks++;
        if (rev_cnt !== rv) begin n_err++; $display("FAIL illegal_rev: got %0d want %0d", rev_cnt, rv); end
        step(1'b1, 4'b0010, 1'b0, 16'h0);
        step(1'b1, 4'b0100, 1'b0, 16'h0);
        step(1'b1, 4'b1000, 1'b0, 16'h0);
        step(1'b1, 4'b0001, 1'b0, 16'h0);
        n_checks++;
        if ({err, rev_cnt} !== {1'b1, rv + 8'd1}) begin
            n_err++; $display("FAIL illegal_sticky: got err=%b rev=%0d want err=1 rev=%0d", err, rev_cnt, rv + 8'd1);
        end
        while (exp_q.size() > 0) begin
            sb_e = exp_q.pop_front(); sb_o = obs_q.pop_front(); n_checks++;
            if (sb_o !== sb_e) begin n_err++; $display("FAIL illegal_sb: got %h want %h", sb_o, sb_e); end
        end
    endtask

    task automatic test_rev_wrap();
        step(1'b0, 4'b0001, 1'b0, 16'h0);
        for (int r = 0; r < 300; r++) begin
            step(1'b1, 4'b0010, 1'b0, 16'h0);
            step(1'b1, 4'b0100, 1'b0, 16'h0);
            step(1'b1, 4'b1000, 1'b0, 16'h0);
            step(1'b1, 4'b0001, 1'b0, 16'h0);
        end
        n_checks++;
        if (rev_cnt !== 8'd44) begin n_err++; $display("FAIL rev_wrap: got %0d want 44", rev_cnt); end
        while (exp_q.size() > 0) begin
            sb_e = exp_q.pop_front(); sb_o = obs_q.pop_front(); n_checks++;
            if (sb_o !== sb_e) begin n_err++; $display("FAIL wrap_sb: got %h want %h", sb_o, sb_e); end
        end
    endtask

    task automatic test_stall();
        step(1'b1, 4'b0010, 1'b0, 16'h0);
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 4'b0100, 1'b0, 16'h0);
            if (i == 15 || i == 16) begin
                n_checks++;
                if (stall !== (i == 16)) begin
                    n_err++; $display("FAIL stall_rise sample %0d: got %b want %b", i, stall, (i == 16));
                end
            end
        end
        step(1'b1, 4'b1000, 1'b0, 16'h0);
        n_checks++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL stall_clear: got %b want 0", stall); end
        for (int i = 0; i < 20; i++) step(1'b1, 4'b1000, 1'b0, 16'h0);
        n_checks++;
        if (stall !== 1'b1) begin n_err++; $display("FAIL stall_hold: got %b want 1", stall); end
        step(1'b0, 4'b1000, 1'b0, 16'h0);
        n_checks++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL stall_reset: got %b want 0", stall); end
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 4'b1000, 1'b0, 16'h0);
            if (i == 15 || i == 16) begin
                n_checks++;
                if (stall !== (i == 16)) begin
                    n_err++; $display("FAIL stall_after_reset sample %0d: got %b want %b", i, stall, (i == 16));
                end
            end
        end
        while (exp_q.size() > 0) begin
            sb_e = exp_q.pop_front(); sb_o = obs_q.pop_front(); n_checks++;
            if (sb_o !== sb_e) begin n_err++; $display("FAIL stall_sb: got %h want %h", sb_o, sb_e); end
        end
    endtask

    task automatic test_random();
        int k;
        step(1'b0, 4'b0001, 1'b0, 16'h0);
        k = 0;
        for (int i = 0; i < 200; i++) begin
            // Mostly rotate; sometimes hold or skip so stalls and odd orders occur.
            case ($urandom_range(0, 9))
                0:       k = k;
                1:       k = k + 2;
                default: k = k + 1;
            endcase
            step(1'b1, 4'b0001 << (k % 4), ($urandom_range(0, 4) == 0), 16'($urandom));
        end
        while (exp_q.size() > 0) begin
            sb_e = exp_q.pop_front(); sb_o = obs_q.pop_front(); n_checks++;
            if (sb_o !== sb_e) begin n_err++; $display("FAIL random_sb: got %h want %h", sb_o, sb_e); end
        end
    endtask

    initial begin
        test_reset();
        test_load_rotate();
        test_load_in_commit();
        test_illegal();
        test_rev_wrap();
        test_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ring_scan_display.md
Name: ring_scan_display

Overview:
- Downstream consumer of the 4-bit one-hot ring counter phase.
- Uses each ring phase as a digit strobe to scan a 4-digit multiplexed 7-segment display.
- New display values are double-buffered and committed only at a revolution boundary.
- Monitors the ring for illegal (non-one-hot) patterns and stalls; counts complete revolutions.

Parameters:
REV_W, 8, width of revolution counter
STALL_CYC, 16, consecutive unchanged-phase samples that flag a stall (>=2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
phase  input  4  one-hot ring phase; bit i selects digit i
load  input  1  capture din into shadow buffer
din  input  16  four hex nibbles; digit i = din[4i+3:4i]
seg  output  7  segments {g,f,e,d,c,b,a}, active-high, registered
an  output  4  digit enables, active-high, registered
pend  output  1  shadow holds an uncommitted value
err  output  1  sticky illegal-phase flag
stall  output  1  phase held constant too long
rev_cnt  output  REV_W  completed revolutions, wraps

Behaviour:
- Reset (reset==0 at posedge) clears the following to 0: seg, an, pend, err, stall, rev_cnt, disp_q, shd_q, prev_phase, stall counter. Any pending load is discarded, including mid-revolution.
- Legal phase: exactly one bit set.
- Load: load==1 -> shd_q<=din, pend<=1. A later load before commit overwrites shd_q.
- Commit condition: pend==1 and phase==4'b0001.
  - At commit: disp_q<=shd_q, pend<=0.
  - seg source in the commit cycle is forwarded from shd_q, so the new value shows from digit0 of that revolution.
- Load in commit cycle:
  - Old shd_q commits.
  - din goes to shd_q.
  - pend stays 1 and commits at the next 0001.
- Output latency is 1 cycle. For legal phase with bit i set: an<=phase, seg<=decode(digit i).
- Decode (hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Illegal phase (0000 or more than one bit set):
  - an<=0, seg<=0, err<=1.
  - No commit; pend is held.
  - No revolution count.
  - err stays 1 until reset.
- Revolution count: prev_phase<=phase every cycle. rev_cnt increments when prev_phase==1000 and phase==0001. It wraps modulo 2^REV_W.
- Stall:
  - The counter increments while phase==prev_phase and saturates at STALL_CYC-1.
  - The counter clears on any change.
  - stall<=1 once phase has been sampled unchanged for STALL_CYC consecutive cycles.
  - stall<=0 on the edge after phase changes.
  - Stall does not block commit or display.
- Any legal one-hot order is displayed. Only the 1000->0001 transition counts as a revolution.

Optional Feature:
BLANK_LEAD_EN
- Defined: leading-zero blanking. For a legal phase selecting digit i (i=3..1), seg<=0 when that nibble and all higher nibbles of the displayed value are 0. an is still driven. Digit0 is never blanked.
- Undefined: all digits are decoded normally (zero shows 3F).

Test Plan:
1. Reset: hold reset=0 for 2 cycles with load=1, phase=0010 -> seg=00, an=0000, pend=0, err=0, stall=0, rev_cnt=0.
2. Load and rotate: load din=16'h1234 at phase=0010 -> pend=1. Then rotate 0100,1000,0001,0010,0100,1000:
   - pend stays 1 until the 0001 edge.
   - Outputs one cycle later: an=0001/seg=66, an=0010/seg=4F, an=0100/seg=5B, an=1000/seg=06.
3. Load in commit cycle: pend=1 with shd=16'h00AB, load din=16'hFFFF at phase=0001 -> digit0 shows B (7C). pend stays 1. The next revolution shows F (71) on all digits.
4. Illegal phase: inject phase=0110 for 1 cycle mid-rotation -> next cycle an=0000, seg=00, err=1. err stays 1 after legal rotation resumes. That revolution is not counted.
5. Revolution wrap: 300 clean 1000->0001 transitions with REV_W=8 -> rev_cnt=44.
6. Stall: hold phase=0100 for 20 cycles -> stall=1 from the 16th sample. Change to 1000 -> stall=0 the next cycle. Assert reset mid-stall -> stall=0 and counter cleared.
